// File: rtl/hba_master.sv
// HBA bus master: one command in flight, select held until the slave xferack, then a one-cycle idle GAP.
// Latency is set by the slave (zero added cycles); cmd_ready only in IDLE. Optional timeout: HBA_MASTER_TIMEOUT_EN.
module hba_master #(
   parameter int DBUS_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  hba_clk,
   input  logic                  hba_reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_rnw,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DBUS_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DBUS_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_timeout,
   output logic                  hba_select,
   output logic                  hba_rnw,
   output logic [ADDR_WIDTH-1:0] hba_abus,
   output logic [DBUS_WIDTH-1:0] hba_dbus,
   input  logic                  hba_xferack,
   input  logic [DBUS_WIDTH-1:0] hba_sdbus
);

   if (TIMEOUT_CYCLES < 4) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 4");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic                    w_accept;
   logic                    w_ack;
   logic                    w_tmo;
   logic                    w_done;
   logic                    r_rnw;
   logic [ADDR_WIDTH-1:0]   r_abus;
   logic [DBUS_WIDTH-1:0]   r_dbus;
   logic                    r_rsp_valid;
   logic [DBUS_WIDTH-1:0]   r_rsp_rdata;

   assign w_accept = (r_state == ST_IDLE) && cmd_valid;
   assign w_ack    = (r_state == ST_XFER) && hba_xferack;
   assign w_done   = w_ack || w_tmo;

   always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Unused encoding falls back to IDLE, where select is already low.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (cmd_valid) w_next_state = ST_XFER;
         ST_XFER: if (w_done)    w_next_state = ST_GAP;
         ST_GAP:                 w_next_state = ST_IDLE;
         default:                w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      hba_select = (r_state == ST_XFER);
      cmd_ready  = (r_state == ST_IDLE);
   end

   always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
         r_rnw       <= 1'b0;
         r_abus      <= '0;
         r_dbus      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_done;
         if (w_accept) begin
            r_rnw  <= cmd_rnw;
            r_abus <= cmd_addr;
            r_dbus <= cmd_wdata;
         end else if ((r_state != ST_XFER) || w_done) begin
            r_rnw  <= 1'b0;
            r_abus <= '0;
            r_dbus <= '0;
         end
         if (w_done) begin
            r_rsp_rdata <= (w_ack && r_rnw) ? hba_sdbus : '0;
         end
      end
   end

   assign hba_rnw   = r_rnw;
   assign hba_abus  = r_abus;
   assign hba_dbus  = r_dbus;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;

`ifdef HBA_MASTER_TIMEOUT_EN
   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_tmo_cnt;
   logic             r_rsp_timeout;

   // An xferack in the final cycle still completes normally.
   assign w_tmo = (r_state == ST_XFER) && !hba_xferack && (r_tmo_cnt == CNT_LAST);

   always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
         r_tmo_cnt     <= '0;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (w_accept) begin
            r_tmo_cnt <= '0;
         end else if ((r_state == ST_XFER) && !hba_xferack) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
         if (w_done) begin
            r_rsp_timeout <= w_tmo;
         end
      end
   end

   assign rsp_timeout = r_rsp_timeout;
`else
   assign w_tmo       = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hba_master.sv
// Scoreboard bench for hba_master: stimulus queues expected bus/response items, a negedge monitor checks them.
module tb_hba_master;
   localparam int DW = 8;
   localparam int AW = 12;
   localparam int TC = 16;

   logic          hba_clk = 1'b0;
   logic          hba_reset_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_rnw = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_timeout;
   logic          hba_select;
   logic          hba_rnw;
   logic [AW-1:0] hba_abus;
   logic [DW-1:0] hba_dbus;
   logic          hba_xferack = 1'b0;
   logic [DW-1:0] hba_sdbus = '0;

   hba_master #(.DBUS_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TC)) dut (
      .hba_clk(hba_clk), .hba_reset_n(hba_reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .hba_select(hba_select), .hba_rnw(hba_rnw), .hba_abus(hba_abus), .hba_dbus(hba_dbus),
      .hba_xferack(hba_xferack), .hba_sdbus(hba_sdbus)
   );

   always #5 hba_clk = ~hba_clk;

   typedef struct {
      int            len;
      logic          rnw;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } bus_t;
   typedef struct {
      logic [DW-1:0] rdata;
      logic          tmo;
   } rsp_t;

   bus_t bus_q[$];
   rsp_t rsp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   int            ack_delay = 3;
   logic [DW-1:0] slv_rdata = '0;
   logic          stray = 1'b0;
   int            sel_cnt = 0;

   bus_t          cur;
   logic          prev_sel = 1'b0;
   int            hi_run = 0;
   int            lo_run = 0;
   int            last_gap = 0;
   int            rsp_cnt = 0;
   logic [DW-1:0] last_rd = '0;
   logic          last_tmo = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave model: acks once select has been seen for ack_delay cycles.
   always @(negedge hba_clk) begin
      sel_cnt     = hba_select ? sel_cnt + 1 : 0;
      hba_xferack = stray || (hba_select && (sel_cnt >= ack_delay));
      hba_sdbus   = (hba_xferack && hba_select && hba_rnw) ? slv_rdata : '0;
   end

   always @(negedge hba_clk) begin
      if (!hba_reset_n) begin
         chk("reset_outputs", {hba_select, rsp_valid, rsp_timeout, hba_rnw, rsp_rdata, hba_abus, hba_dbus}, 32'h0);
         prev_sel = 1'b0;
         hi_run   = 0;
         lo_run   = 0;
         last_rd  = '0;
         last_tmo = 1'b0;
      end else begin
         if (hba_select) begin
            chk("cmd_ready_xfer", cmd_ready, 0);
            if (!prev_sel) begin
               if (bus_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_select: got select=1 required no transfer at %0t", $time);
                  cur.len = -1; cur.rnw = hba_rnw; cur.addr = hba_abus; cur.wdata = hba_dbus;
               end else begin
                  cur = bus_q.pop_front();
                  chk("abus", hba_abus, cur.addr);
                  chk("dbus", hba_dbus, cur.wdata);
                  chk("rnw", hba_rnw, cur.rnw);
               end
               last_gap = lo_run;
               hi_run   = 0;
            end else begin
               chk("bus_stable", {hba_rnw, hba_dbus, hba_abus}, {cur.rnw, cur.wdata, cur.addr});
            end
            hi_run++;
            lo_run = 0;
         end else begin
            if (prev_sel) begin
               if (cur.len >= 0) chk("select_len", hi_run, cur.len);
               chk("cmd_ready_gap", cmd_ready, 0);
            end else begin
               chk("cmd_ready_idle", cmd_ready, 1);
            end
            chk("bus_idle_zero", {hba_rnw, hba_dbus, hba_abus}, 32'h0);
            lo_run++;
         end
         prev_sel = hba_select;
         if (rsp_valid) begin
            rsp_cnt++;
            if (rsp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 required 0 at %0t", $time);
            end else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, r.rdata);
               chk("rsp_timeout", rsp_timeout, r.tmo);
            end
            last_rd  = rsp_rdata;
            last_tmo = rsp_timeout;
         end else begin
            chk("rsp_hold", {rsp_timeout, rsp_rdata}, {last_tmo, last_rd});
         end
      end
   end

   task automatic send(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int len, input logic [DW-1:0] exp_rd, input logic exp_tmo, input bit want_rsp);
      bus_t b;
      rsp_t r;
      int   g;
      b.len = len; b.rnw = rnw; b.addr = a; b.wdata = d;
      bus_q.push_back(b);
      if (want_rsp) begin
         r.rdata = exp_rd; r.tmo = exp_tmo;
         rsp_q.push_back(r);
      end
      cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_wdata = d;
      g = 0;
      while (!cmd_ready && g < 500) begin
         @(negedge hba_clk);
         g++;
      end
      if (g >= 500) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_wait: got cmd_ready=0 for 500 cycles required 1");
      end
      @(posedge hba_clk);
      #1;
      // Scramble the command inputs while the transfer runs; the bus must not follow.
      cmd_valid = 1'b0; cmd_rnw = ~rnw; cmd_addr = ~a; cmd_wdata = ~d;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((bus_q.size() != 0 || rsp_q.size() != 0 || hba_select) && g < 3000) begin
         @(negedge hba_clk);
         g++;
      end
      if (g >= 3000) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: got %0d bus / %0d rsp items pending required 0", bus_q.size(), rsp_q.size());
      end
      repeat (3) @(negedge hba_clk);
   endtask

   initial begin
      int saved;
      #1;
      chk("reset_select", hba_select, 0);
      chk("reset_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, 0);
      repeat (3) @(negedge hba_clk);
      hba_reset_n = 1'b1;
      @(negedge hba_clk);
      #1;
      chk("ready_after_reset", cmd_ready, 1);

      ack_delay = 3;
      send(1'b0, 12'h001, 8'hA5, 3, 8'h00, 1'b0, 1'b1);
      drain();

      ack_delay = 2; slv_rdata = 8'h3C;
      send(1'b1, 12'h002, 8'h00, 2, 8'h3C, 1'b0, 1'b1);
      drain();

      ack_delay = 1; slv_rdata = 8'hC3;
      send(1'b1, 12'hFFF, 8'h00, 1, 8'hC3, 1'b0, 1'b1);
      drain();

      ack_delay = 2; slv_rdata = 8'h99;
      send(1'b0, 12'h123, 8'h5A, 2, 8'h00, 1'b0, 1'b1);
      send(1'b1, 12'h456, 8'h00, 2, 8'h99, 1'b0, 1'b1);
      @(negedge hba_clk);
      #1;
      chk("b2b_gap", last_gap, 2);
      drain();

      ack_delay = TC; slv_rdata = 8'h81;
      send(1'b1, 12'h0C0, 8'h00, TC, 8'h81, 1'b0, 1'b1);
      drain();

`ifdef HBA_MASTER_TIMEOUT_EN
      ack_delay = 1000; slv_rdata = 8'hFF;
      send(1'b1, 12'h0AB, 8'h00, TC, 8'h00, 1'b1, 1'b1);
      drain();
`else
      ack_delay = 101; slv_rdata = 8'h7E;
      send(1'b1, 12'h0AB, 8'h00, 101, 8'h7E, 1'b0, 1'b1);
      drain();
`endif

      saved = rsp_cnt;
      stray = 1'b1;
      repeat (3) @(negedge hba_clk);
      stray = 1'b0;
      repeat (3) @(negedge hba_clk);
      chk("stray_ack_no_rsp", rsp_cnt, saved);

      ack_delay = 10; slv_rdata = 8'h11;
      send(1'b1, 12'h3FF, 8'h00, -1, 8'h00, 1'b0, 1'b0);
      repeat (3) @(negedge hba_clk);
      #2;
      saved = rsp_cnt;
      hba_reset_n = 1'b0;
      #1;
      chk("reset_abort_select", hba_select, 0);
      repeat (2) @(negedge hba_clk);
      hba_reset_n = 1'b1;
      repeat (15) @(negedge hba_clk);
      chk("reset_abort_no_rsp", rsp_cnt, saved);

      ack_delay = 3;
      send(1'b0, 12'h010, 8'h42, 3, 8'h00, 1'b0, 1'b1);
      drain();

      chk("bus_q_empty", bus_q.size(), 0);
      chk("rsp_q_empty", rsp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got simulation still running required completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/hba_master.md
HBA_MASTER -- requirements
Module: hba_master

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- DBUS_WIDTH, 8, HBA data bus width.
- ADDR_WIDTH, 12, HBA address bus width (peripheral address bits plus register address bits).
- TIMEOUT_CYCLES, 16, XFER cycles without hba_xferack before abort; minimum 4.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- hba_clk, in, 1, the only clock; all logic samples on its rising edge.
- hba_reset_n, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, command accepted when cmd_valid=1 at this edge.
- cmd_rnw, in, 1, 1=read, 0=write.
- cmd_addr, in, ADDR_WIDTH, target address.
- cmd_wdata, in, DBUS_WIDTH, write data.
- rsp_valid, out, 1, one-cycle completion pulse.
- rsp_rdata, out, DBUS_WIDTH, read data; valid with rsp_valid.
- rsp_timeout, out, 1, 1 = transfer aborted by timeout; valid with rsp_valid.
- hba_select, out, 1, transfer in progress to the slaves.
- hba_rnw, out, 1, bus direction to the slaves.
- hba_abus, out, ADDR_WIDTH, address bus.
- hba_dbus, out, DBUS_WIDTH, write data bus.
- hba_xferack, in, 1, OR of all slave xferacks.
- hba_sdbus, in, DBUS_WIDTH, OR of all slave output data buses (each slave drives zero when inactive).

Function
REQ-003 FSM states SHALL be IDLE, XFER, GAP; any other encoding SHALL return to IDLE on the next edge with hba_select=0.
REQ-004 cmd_ready SHALL be 1 only in IDLE.
REQ-005 IDLE with cmd_valid=1: at that edge, latch cmd_rnw/cmd_addr/cmd_wdata into hba_rnw/hba_abus/hba_dbus, set hba_select=1, clear the timeout counter, go to XFER.
REQ-006 In XFER, hba_select, hba_rnw, hba_abus and hba_dbus SHALL stay stable; cmd_* changes SHALL be ignored.
REQ-007 XFER with hba_xferack=1, at that edge:
- hba_select<=0, rsp_valid<=1, rsp_timeout<=0, go to GAP.
- Read: rsp_rdata<=hba_sdbus, sampled the same cycle as the xferack.
- Write: rsp_rdata<=0.
REQ-008 GAP SHALL last exactly one cycle with hba_select=0, then IDLE; back-to-back commands therefore see at least two cycles of hba_select=0 between transfers.
REQ-009 rsp_valid SHALL be high for exactly one cycle per accepted command; rsp_rdata and rsp_timeout SHALL hold until the next rsp_valid.
REQ-010 hba_xferack outside XFER SHALL be ignored: no rsp_valid, no state change.
REQ-011 hba_abus, hba_dbus and hba_rnw SHALL return to 0 when entering GAP, so the bus idles at zero.
REQ-012 Minimum accept-to-rsp_valid latency is slave-determined; the master adds no cycles beyond sampling hba_xferack.

Reset
REQ-013 While hba_reset_n=0, asynchronously:
- State=IDLE.
- hba_select, hba_rnw, hba_abus, hba_dbus, rsp_valid, rsp_rdata, rsp_timeout = 0.
- Timeout counter = 0.
- cmd_ready=1 once reset is released.
REQ-014 Reset asserted mid-XFER SHALL drop hba_select immediately and emit no rsp_valid for the aborted command.

Configuration
REQ-015 Macro HBA_MASTER_TIMEOUT_EN defined:
- In XFER, the counter SHALL increment every cycle without hba_xferack.
- The cycle it equals TIMEOUT_CYCLES-1 with hba_xferack=0 SHALL behave as REQ-007, but with rsp_timeout<=1 and rsp_rdata<=0.
- hba_xferack and timeout in the same cycle: hba_xferack wins, rsp_timeout=0.
REQ-016 Macro HBA_MASTER_TIMEOUT_EN undefined: no counter logic; XFER waits indefinitely for hba_xferack; rsp_timeout is tied to 0.

Verification
REQ-017 Write cmd addr=0x001, wdata=0xA5; slave model acks 3 cycles after select -> select high 3 cycles with abus=0x001, dbus=0xA5, rnw=0; rsp_valid one pulse, rsp_timeout=0.
REQ-018 Read cmd addr=0x002; slave returns sdbus=0x3C with xferack -> rsp_rdata=0x3C, rsp_valid one cycle, hba_select low the next cycle.
REQ-019 cmd_valid held high for two commands -> second select rises exactly 2 cycles after the first select falls; cmd_ready low during XFER and GAP.
REQ-020 With HBA_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, no slave response -> select high 16 cycles, rsp_timeout=1, rsp_rdata=0; a later stray xferack in IDLE produces no rsp_valid.
REQ-021 hba_reset_n pulsed low during XFER of a read -> select=0 immediately, no rsp_valid; the next command after release completes normally.
REQ-022 Without HBA_MASTER_TIMEOUT_EN, ack withheld 100 cycles and then given -> a single normal response, rsp_timeout=0.
